// File: rtl/reaction_delay_timer.sv
// Responder half of the start-lights countdown handshake: answers a start_delay
// request with time_out after MIN_DELAY plus a pseudo-random number of ms ticks.
module reaction_delay_timer #(
  parameter int LFSR_W    = 7,
  parameter int MIN_DELAY = 250,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              en_fsr,
  input  logic              start_delay,
  output logic              time_out,
  output logic              busy,
  output logic [CNT_W-1:0]  delay_val,
  output logic [LFSR_W-1:0] lfsr_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Fibonacci step for the maximal-length x^7+x^6+1 polynomial.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], cur[LFSR_W-1] ^ cur[LFSR_W-2]};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LFSR_W-1:0]  lfsr_r;
  logic [CNT_W-1:0]   elapsed_r;
  logic [CNT_W-1:0]   elapsed_nxt_s;
  logic [CNT_W-1:0]   delay_val_r;
  logic [CNT_W-1:0]   delay_nxt_s;
  logic               time_out_r;
  logic               time_out_nxt_s;
  logic               busy_r;
  logic               busy_nxt_s;
  logic               start_prev_r;
  logic               start_rise_s;

  assign start_rise_s = start_delay & ~start_prev_r;

  // Free-running LFSR and start-edge history, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r       <= {{(LFSR_W-1){1'b0}}, 1'b1};
      start_prev_r <= 1'b1;
    end else begin
      start_prev_r <= start_delay;
      if (en_fsr) begin
        lfsr_r <= lfsr_next(lfsr_r);
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      elapsed_r   <= {CNT_W{1'b0}};
      delay_val_r <= {CNT_W{1'b0}};
      time_out_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      elapsed_r   <= elapsed_nxt_s;
      delay_val_r <= delay_nxt_s;
      time_out_r  <= time_out_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Next-state and next-register values; abort outranks a same-cycle tick.
  always_comb begin
    state_nxt_s    = state_r;
    elapsed_nxt_s  = elapsed_r;
    delay_nxt_s    = delay_val_r;
    time_out_nxt_s = time_out_r;
    busy_nxt_s     = busy_r;
    case (state_r)
      IDLE: begin
        time_out_nxt_s = 1'b0;
        if (start_rise_s) begin
          delay_nxt_s   = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_r);
          elapsed_nxt_s = {CNT_W{1'b0}};
          busy_nxt_s    = 1'b1;
          state_nxt_s   = COUNT;
        end else begin
          busy_nxt_s    = 1'b0;
          state_nxt_s   = IDLE;
        end
      end
      COUNT: begin
        if (!start_delay) begin
          state_nxt_s    = IDLE;
          elapsed_nxt_s  = {CNT_W{1'b0}};
          time_out_nxt_s = 1'b0;
          busy_nxt_s     = 1'b0;
        end else if (tick) begin
          if (elapsed_r == delay_val_r - CNT_W'(1)) begin
            state_nxt_s    = DONE;
            time_out_nxt_s = 1'b1;
            busy_nxt_s     = 1'b0;
          end else begin
            elapsed_nxt_s  = elapsed_r + CNT_W'(1);
            busy_nxt_s     = 1'b1;
          end
        end else begin
          busy_nxt_s = 1'b1;
        end
      end
      DONE: begin
        busy_nxt_s = 1'b0;
        if (!start_delay) begin
          time_out_nxt_s = 1'b0;
          state_nxt_s    = IDLE;
        end else begin
          time_out_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        time_out_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
      end
    endcase
  end

  assign time_out  = time_out_r;
  assign busy      = busy_r;
  assign delay_val = delay_val_r;
  assign lfsr_q    = lfsr_r;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Directed, self-checking bench for reaction_delay_timer.
module tb_reaction_delay_timer;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       en_fsr;
  logic       start_delay;
  logic       time_out;
  logic       busy;
  logic [9:0] delay_val;
  logic [6:0] lfsr_q;

  int n_cmp;
  int n_err;

  reaction_delay_timer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .en_fsr      (en_fsr),
    .start_delay (start_delay),
    .time_out    (time_out),
    .busy        (busy),
    .delay_val   (delay_val),
    .lfsr_q      (lfsr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic start_lvl);
    rst = 1'b1; tick = 1'b0; en_fsr = 1'b0; start_delay = start_lvl;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    logic [6:0] exp_seq [7];
    exp_seq = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
    do_reset(1'b0);
    n_cmp++; if (lfsr_q !== 7'h01) begin n_err++; $display("FAIL reset_lfsr got %h want 01", lfsr_q); end
    n_cmp++; if (delay_val !== 10'd0) begin n_err++; $display("FAIL reset_delay got %0d want 0", delay_val); end
    n_cmp++; if (busy !== 1'b0 || time_out !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy=%b to=%b want 0 0", busy, time_out); end
    en_fsr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++; if (lfsr_q !== exp_seq[i]) begin n_err++; $display("FAIL lfsr_seq[%0d] got %h want %h", i, lfsr_q, exp_seq[i]); end
    end
    n_cmp++; if (busy !== 1'b0 || time_out !== 1'b0) begin n_err++; $display("FAIL lfsr_flags got busy=%b to=%b want 0 0", busy, time_out); end
  endtask

  task automatic test_full_delay();
    do_reset(1'b0);
    en_fsr = 1'b1;
    step(); step(); step();
    en_fsr = 1'b0;
    n_cmp++; if (lfsr_q !== 7'h08) begin n_err++; $display("FAIL full_lfsr got %h want 08", lfsr_q); end
    start_delay = 1'b1; step();
    n_cmp++; if (delay_val !== 10'd258) begin n_err++; $display("FAIL full_delay got %0d want 258", delay_val); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %b want 1", busy); end
    pulse_ticks(257);
    n_cmp++; if (time_out !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL full_257 got to=%b busy=%b want 0 1", time_out, busy); end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (time_out !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL full_258 got to=%b busy=%b want 1 0", time_out, busy); end
    pulse_ticks(3);
    n_cmp++; if (time_out !== 1'b1) begin n_err++; $display("FAIL done_hold got %b want 1", time_out); end
    n_cmp++; if (delay_val !== 10'd258) begin n_err++; $display("FAIL done_delay got %0d want 258", delay_val); end
    start_delay = 1'b0; step();
    n_cmp++; if (time_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL done_clear got to=%b busy=%b want 0 0", time_out, busy); end
  endtask

  task automatic test_abort();
    do_reset(1'b0);
    en_fsr = 1'b1; step(); step(); en_fsr = 1'b0;
    start_delay = 1'b1; step();
    n_cmp++; if (delay_val !== 10'd254) begin n_err++; $display("FAIL abort_delay got %0d want 254", delay_val); end
    pulse_ticks(100);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre got %b want 1", busy); end
    start_delay = 1'b0; tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (busy !== 1'b0 || time_out !== 1'b0) begin n_err++; $display("FAIL abort_idle got busy=%b to=%b want 0 0", busy, time_out); end
    pulse_ticks(200);
    n_cmp++; if (time_out !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_quiet got to=%b busy=%b want 0 0", time_out, busy); end
    // lfsr 04 -> 08 -> 10 -> 20, so the recapture is 250 + 32
    en_fsr = 1'b1; step(); step(); step(); en_fsr = 1'b0;
    start_delay = 1'b1; step();
    n_cmp++; if (delay_val !== 10'd282 || busy !== 1'b1) begin n_err++; $display("FAIL abort_recap got delay=%0d busy=%b want 282 1", delay_val, busy); end
    // a count restarted from zero needs all 282 ticks
    pulse_ticks(281);
    n_cmp++; if (time_out !== 1'b0) begin n_err++; $display("FAIL abort_281 got %b want 0", time_out); end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (time_out !== 1'b1) begin n_err++; $display("FAIL abort_282 got %b want 1", time_out); end
    start_delay = 1'b0; step();
  endtask

  task automatic test_held_start_and_rst();
    do_reset(1'b1);
    step(); step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_start got busy=%b want 0", busy); end
    start_delay = 1'b0; step();
    start_delay = 1'b1; step();
    n_cmp++; if (busy !== 1'b1 || delay_val !== 10'd251) begin n_err++; $display("FAIL held_rearm got busy=%b delay=%0d want 1 251", busy, delay_val); end
    pulse_ticks(50);
    rst = 1'b1; tick = 1'b1; en_fsr = 1'b1; step();
    rst = 1'b0; tick = 1'b0; en_fsr = 1'b0;
    n_cmp++; if (busy !== 1'b0 || time_out !== 1'b0 || lfsr_q !== 7'h01 || delay_val !== 10'd0) begin
      n_err++; $display("FAIL midcount_rst got busy=%b to=%b lfsr=%h delay=%0d want 0 0 01 0", busy, time_out, lfsr_q, delay_val);
    end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_held_start got busy=%b want 0", busy); end
    start_delay = 1'b0; step();
  endtask

  task automatic test_back_to_back_tick_on_rise();
    logic [6:0] prev;
    do_reset(1'b0);
    en_fsr = 1'b1; step();
    start_delay = 1'b1; tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (delay_val !== 10'd252 || lfsr_q !== 7'h04) begin n_err++; $display("FAIL rise_tick got delay=%0d lfsr=%h want 252 04", delay_val, lfsr_q); end
    step();
    n_cmp++; if (lfsr_q !== 7'h08 || delay_val !== 10'd252) begin n_err++; $display("FAIL rise_adv got lfsr=%h delay=%0d want 08 252", lfsr_q, delay_val); end
    pulse_ticks(251);
    n_cmp++; if (time_out !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rise_251 got to=%b busy=%b want 0 1", time_out, busy); end
    tick = 1'b1; step(); tick = 1'b0;
    n_cmp++; if (time_out !== 1'b1) begin n_err++; $display("FAIL rise_252 got %b want 1", time_out); end
    prev = lfsr_q; step();
    n_cmp++; if (lfsr_q !== {prev[5:0], prev[6] ^ prev[5]} || delay_val !== 10'd252) begin
      n_err++; $display("FAIL rise_lfsr_run got lfsr=%h delay=%0d want %h 252", lfsr_q, delay_val, {prev[5:0], prev[6] ^ prev[5]});
    end
    start_delay = 1'b0; step();
    n_cmp++; if (time_out !== 1'b0) begin n_err++; $display("FAIL rise_clear got %b want 0", time_out); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; tick = 1'b0; en_fsr = 1'b0; start_delay = 1'b0;
    test_reset();
    test_full_delay();
    test_abort();
    test_held_start_and_rst();
    test_back_to_back_tick_on_rise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
